// File: rtl/lc3_mem_pkg.sv
// Shared types for the LC-3 memory path: access sequencer states, grant
// encoding and the wait-state counter width.
package lc3_mem_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } mem_state_t;

    typedef enum logic {
        GNT_CPU,
        GNT_DMA
    } mem_grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shared-RAM access sequencer. Arbitrates between the CPU memory path and the
// DMA/loader port (round-robin on ties), holds each access for WAIT_CYCLES
// cycles of chip select, then acknowledges it with a one-cycle ready pulse.
// Every RAM-facing and requester-facing output comes straight from a register.
module mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ready,

    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    // Reject wait-state counts the 4-bit counter cannot represent.
    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
            $error("mem_arbiter: WAIT_CYCLES must be within 1..15");
        end
    endgenerate

    localparam logic [WAIT_W-1:0] CNT_LOAD     = WAIT_W'(WAIT_CYCLES - 1);
    localparam logic              SINGLE_CYCLE = (WAIT_CYCLES == 1);

    mem_state_t        state_q;
    mem_grant_t        grant_q;
    mem_grant_t        last_grant_q;
    logic [WAIT_W-1:0] cnt_q;
    logic              acc_we_q;
    logic              ram_cs_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;
    logic              cpu_ready_q;
    logic              dma_ready_q;

    mem_grant_t        pick_d;
    logic              sel_we_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_wdata_d;

    // Pick the winner for the next grant and mux its request fields; only
    // consumed in IDLE, and only ever lands in registers.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        pick_d      = GNT_CPU;
        sel_we_d    = cpu_we;
        sel_addr_d  = cpu_addr;
        sel_wdata_d = cpu_wdata;

        if (cpu_req && dma_req) begin
            pick_d = (last_grant_q == GNT_DMA) ? GNT_CPU : GNT_DMA;
        end else if (dma_req) begin
            pick_d = GNT_DMA;
        end

        if (pick_d == GNT_DMA) begin
            sel_we_d    = dma_we;
            sel_addr_d  = dma_addr;
            sel_wdata_d = dma_wdata;
        end
    end

    // Access sequencer: IDLE grants and latches, ACCESS counts wait states
    // and strobes the write on the last one, DONE pulses ready.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            grant_q      <= GNT_CPU;
            last_grant_q <= GNT_DMA;
            cnt_q        <= '0;
            acc_we_q     <= 1'b0;
            ram_cs_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
            cpu_ready_q  <= 1'b0;
            dma_ready_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values, independent of statement order.
            cpu_ready_q <= 1'b0;
            dma_ready_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        grant_q     <= pick_d;
                        acc_we_q    <= sel_we_d;
                        ram_addr_q  <= sel_addr_d;
                        ram_wdata_q <= sel_wdata_d;
                        cnt_q       <= CNT_LOAD;
                        ram_cs_q    <= 1'b1;
                        ram_we_q    <= sel_we_d && SINGLE_CYCLE;
                        state_q     <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (cnt_q == '0) begin
                        ram_cs_q <= 1'b0;
                        ram_we_q <= 1'b0;
                        state_q  <= DONE;
                        if (grant_q == GNT_CPU) begin
                            cpu_ready_q <= 1'b1;
                            if (!acc_we_q) cpu_rdata_q <= ram_rdata;
                        end else begin
                            dma_ready_q <= 1'b1;
                            if (!acc_we_q) dma_rdata_q <= ram_rdata;
                        end
                    end else begin
                        cnt_q    <= cnt_q - WAIT_W'(1);
                        ram_we_q <= acc_we_q && (cnt_q == WAIT_W'(1));
                    end
                end

                DONE: begin
                    last_grant_q <= grant_q;
                    state_q      <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_cs    = ram_cs_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign dma_ready = dma_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a WAIT_CYCLES=2 instance on a behavioural RAM,
// checked through an expected-response queue popped on every ready pulse,
// plus a WAIT_CYCLES=1 instance for the short-access timing.
module tb_mem_arbiter;

    localparam int W = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance signals
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] dma_addr = '0, dma_wdata = '0;
    logic [15:0] dma_rdata;
    logic        dma_ready;
    logic        ram_cs, ram_we;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;

    // Short-wait instance signals
    logic        d1_cpu_req = 1'b0;
    logic [15:0] d1_cpu_addr = '0;
    logic [15:0] d1_cpu_rdata, d1_dma_rdata;
    logic        d1_cpu_ready, d1_dma_ready;
    logic        d1_ram_cs, d1_ram_we;
    logic [15:0] d1_ram_addr, d1_ram_wdata, d1_ram_rdata;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W)) u_dut (
        .CLK(clk), .RST(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) u_dut1 (
        .CLK(clk), .RST(rst_n),
        .cpu_req(d1_cpu_req), .cpu_we(1'b0), .cpu_addr(d1_cpu_addr), .cpu_wdata(16'h0000),
        .cpu_rdata(d1_cpu_rdata), .cpu_ready(d1_cpu_ready),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(16'h0000), .dma_wdata(16'h0000),
        .dma_rdata(d1_dma_rdata), .dma_ready(d1_dma_ready),
        .ram_cs(d1_ram_cs), .ram_we(d1_ram_we), .ram_addr(d1_ram_addr), .ram_wdata(d1_ram_wdata),
        .ram_rdata(d1_ram_rdata)
    );

    // Behavioural RAM for the main instance; preload goes through the poke port.
    logic [15:0] mem [0:65535];
    logic        poke_en = 1'b0;
    logic [15:0] poke_addr = '0, poke_data = '0;

    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
        if (poke_en) mem[poke_addr] <= poke_data;
    end

    // The short-wait instance reads a fixed pattern: data = addr ^ 16'hA5A5.
    assign d1_ram_rdata = d1_ram_addr ^ 16'hA5A5;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          is_dma;
        bit          is_read;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    // Bus observers and scoreboard monitor
    int          cs_cnt = 0, we_cnt = 0, unstable = 0;
    logic [15:0] we_addr = '0, we_data = '0, prev_addr = '0, prev_wdata = '0;
    logic        prev_cs = 1'b0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_cs) begin
                cs_cnt++;
                if (prev_cs && (ram_addr !== prev_addr || ram_wdata !== prev_wdata)) unstable++;
            end
            if (ram_cs && ram_we) begin
                we_cnt++;
                we_addr = ram_addr;
                we_data = ram_wdata;
            end
            prev_cs    = ram_cs;
            prev_addr  = ram_addr;
            prev_wdata = ram_wdata;

            if (cpu_ready || dma_ready) begin
                check("ready_onehot", 32'(cpu_ready & dma_ready), 0);
                if (sb.size() == 0) begin
                    check("unexpected_ready", {30'b0, dma_ready, cpu_ready}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("ready_port", 32'(dma_ready), 32'(mon_e.is_dma));
                    check("ready_cycle", cyc, mon_e.cyc);
                    check("rdata", mon_e.is_dma ? dma_rdata : cpu_rdata, mon_e.data);
                end
            end
        end else begin
            prev_cs = 1'b0;
        end
    end

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    task automatic clear_obs();
        cs_cnt   = 0;
        we_cnt   = 0;
        unstable = 0;
    endtask

    task automatic wait_ready(input bit is_dma);
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (is_dma ? dma_ready : cpu_ready) break;
        end
        if (k == 40) check("ready_timeout", 32'(is_dma ? dma_ready : cpu_ready), 1);
    endtask

    // One access on one port; exp_rd is the rdata value expected at ready.
    task automatic access(input bit is_dma, input bit wr, input logic [15:0] a,
                          input logic [15:0] wd, input logic [15:0] exp_rd);
        exp_t e;
        @(negedge clk);
        if (is_dma) begin
            dma_we = wr; dma_addr = a; dma_wdata = wd; dma_req = 1'b1;
        end else begin
            cpu_we = wr; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
        end
        e.is_dma  = is_dma;
        e.is_read = !wr;
        e.data    = exp_rd;
        e.cyc     = cyc + 1 + W;
        sb.push_back(e);
        wait_ready(is_dma);
        cpu_req = 1'b0;
        dma_req = 1'b0;
    endtask

    // Both ports read together, each holding its request for n completions.
    task automatic run_both(input bit first_dma, input int n,
                            input logic [15:0] ca, input logic [15:0] cexp,
                            input logic [15:0] da, input logic [15:0] dexp);
        exp_t e;
        int   got_c = 0;
        int   got_d = 0;
        @(negedge clk);
        cpu_we = 1'b0; cpu_addr = ca; cpu_req = 1'b1;
        dma_we = 1'b0; dma_addr = da; dma_req = 1'b1;
        for (int i = 0; i < 2 * n; i++) begin
            e.is_dma  = first_dma ^ i[0];
            e.is_read = 1'b1;
            e.data    = e.is_dma ? dexp : cexp;
            e.cyc     = cyc + 1 + W + i * (W + 2);
            sb.push_back(e);
        end
        for (int k = 0; k < 200 && (cpu_req || dma_req); k++) begin
            @(negedge clk);
            if (cpu_ready) begin
                got_c++;
                if (got_c == n) cpu_req = 1'b0;
            end
            if (dma_ready) begin
                got_d++;
                if (got_d == n) dma_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        check("both_cpu_count", got_c, n);
        check("both_dma_count", got_d, n);
    endtask

    // Directed sequence
    initial begin
        int c0;
        int k;
        logic [15:0] w1_exp [3];
        w1_exp[0] = 16'hA5B5;
        w1_exp[1] = 16'hA5B4;
        w1_exp[2] = 16'hA5B7;

        poke(16'h3000, 16'h1234);
        poke(16'h0040, 16'h0000);
        poke(16'h0100, 16'hAAAA);
        poke(16'h0200, 16'h5555);
        poke(16'h0050, 16'h7777);
        poke(16'hFFFF, 16'h9999);
        poke(16'h0060, 16'h0000);

        // Reset state
        check("rst_ram_cs", 32'(ram_cs), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_cpu_ready", 32'(cpu_ready), 0);
        check("rst_dma_ready", 32'(dma_ready), 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_dma_rdata", dma_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // CPU read of 0x3000
        clear_obs();
        access(1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234);
        repeat (3) @(negedge clk);
        check("t1_cs_cycles", cs_cnt, W);
        check("t1_we_cycles", we_cnt, 0);

        // DMA write 0xBEEF to 0x0040, then CPU reads it back
        clear_obs();
        access(1'b1, 1'b1, 16'h0040, 16'hBEEF, 16'h0000);
        repeat (3) @(negedge clk);
        check("t2_cs_cycles", cs_cnt, W);
        check("t2_we_cycles", we_cnt, 1);
        check("t2_we_addr", we_addr, 16'h0040);
        check("t2_we_data", we_data, 16'hBEEF);
        access(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF);
        check("t2_cpu_rdata_hold", cpu_rdata, 16'hBEEF);

        // DMA read, leaving DMA as last grant
        access(1'b1, 1'b0, 16'h0200, 16'h0000, 16'h5555);

        // Simultaneous held requests: CPU, DMA, CPU, DMA
        run_both(1'b0, 2, 16'h0100, 16'hAAAA, 16'h0200, 16'h5555);

        // CPU read with address changed and request dropped mid-access
        repeat (2) @(negedge clk);
        clear_obs();
        @(negedge clk);
        cpu_we = 1'b0; cpu_addr = 16'h0050; cpu_req = 1'b1;
        begin
            exp_t e;
            e.is_dma = 1'b0; e.is_read = 1'b1; e.data = 16'h7777; e.cyc = cyc + 1 + W;
            sb.push_back(e);
        end
        @(negedge clk);
        check("t4_in_access", 32'(ram_cs), 1);
        cpu_addr = 16'hFFFF;
        cpu_req  = 1'b0;
        wait_ready(1'b0);
        repeat (4) @(negedge clk);
        check("t4_addr_stable", unstable, 0);
        check("t4_cs_cycles", cs_cnt, W);
        check("t4_cpu_rdata", cpu_rdata, 16'h7777);

        // Reset in the second ACCESS cycle of a CPU write
        @(negedge clk);
        cpu_we = 1'b1; cpu_addr = 16'h0060; cpu_wdata = 16'h1111; cpu_req = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_we_before_rst", 32'(ram_we), 1);
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        #1;
        check("t5_rst_cs", 32'(ram_cs), 0);
        check("t5_rst_we", 32'(ram_we), 0);
        check("t5_rst_addr", ram_addr, 0);
        check("t5_rst_cpu_ready", 32'(cpu_ready), 0);
        check("t5_rst_cpu_rdata", cpu_rdata, 0);
        check("t5_rst_dma_rdata", dma_rdata, 0);
        @(posedge clk);
        #1;
        check("t5_write_aborted", mem[16'h0060], 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_both(1'b0, 1, 16'h3000, 16'h1234, 16'h0040, 16'hBEEF);
        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        // WAIT_CYCLES=1 instance: held CPU request, a read every 3 cycles
        @(negedge clk);
        d1_cpu_addr = 16'h0010;
        d1_cpu_req  = 1'b1;
        c0 = cyc;
        for (int r = 0; r < 3; r++) begin
            for (k = 0; k < 20; k++) begin
                @(negedge clk);
                if (d1_cpu_ready) break;
            end
            if (k == 20) check("w1_timeout", 32'(d1_cpu_ready), 1);
            check("w1_cycle", cyc, c0 + 2 + 3 * r);
            check("w1_rdata", d1_cpu_rdata, w1_exp[r]);
            d1_cpu_addr = d1_cpu_addr + 16'h0001;
            if (r == 2) d1_cpu_req = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("w1_idle_cs", 32'(d1_ram_cs), 0);
        check("w1_no_we", 32'(d1_ram_we), 0);
        check("w1_dma_ready", 32'(d1_dma_ready), 0);
        check("w1_dma_rdata", d1_dma_rdata, 0);
        check("w1_ram_wdata", d1_ram_wdata, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit so a stuck handshake still ends the run.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, got cycle %0d, expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
